// File: rtl/tiny_dmem_if.sv
// CPU data-bus and output-FIFO stream bundle for tiny_dmem.
// The master side is the CPU/downstream environment; the slave side is the memory block.
interface tiny_dmem_if;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdat;
    logic [7:0] ram_rdat;
    logic       ram_rd_;
    logic       ram_wr_;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output ram_addr, ram_wdat, ram_rd_, ram_wr_, out_ready,
        input  ram_rdat, out_data, out_valid
    );

    modport slave (
        input  ram_addr, ram_wdat, ram_rd_, ram_wr_, out_ready,
        output ram_rdat, out_data, out_valid
    );
endinterface

// File: rtl/tiny_dmem.sv
// Data memory responder for a single-cycle CPU.
// Byte RAM below IO_BASE, plus a small I/O window with an output FIFO,
// a status register and a down-counting timer.
// Reads are combinational; writes commit on the rising clock edge.
module tiny_dmem #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  IO_BASE    = 8'hF0
) (
    input logic        clk,
    input logic        rst_,
    tiny_dmem_if.slave bus
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

    // Storage (never reset)
    logic [7:0]    mem_q  [0:255];
    logic [7:0]    fifo_q [0:FIFO_DEPTH-1];

    // Control state
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic [7:0]    tcount_q, tcount_d;
    logic [7:0]    treload_q, treload_d;
    logic          exp_q, exp_d;
    logic          ovf_q, ovf_d;

    // Decode
    logic          wr_en, rd_en, in_ram;
    logic [7:0]    io_off;
    logic          sel_out, sel_status, sel_trl;
    logic          full, empty, push, pop, push_ok, status_rd;
    logic [7:0]    status;

    assign wr_en      = !bus.ram_wr_;
    assign rd_en      = !bus.ram_rd_;
    assign in_ram     = bus.ram_addr < IO_BASE;
    assign io_off     = bus.ram_addr - IO_BASE;
    assign sel_out    = !in_ram && (io_off == 8'd0);
    assign sel_status = !in_ram && (io_off == 8'd1);
    assign sel_trl    = !in_ram && (io_off == 8'd2);

    assign full      = (cnt_q == FULL_CNT);
    assign empty     = (cnt_q == '0);
    assign pop       = !empty && bus.out_ready;
    assign push      = wr_en && sel_out;
    // A full FIFO still accepts a push when a pop frees a slot at the same edge
    assign push_ok   = push && (!full || pop);
    assign status_rd = rd_en && sel_status;
    assign status    = {4'b0000, ovf_q, exp_q, empty, full};

    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : fifo_q[rptr_q];

    // Combinational read mux; returns pre-write contents when a write is also pending
    always_comb begin
        bus.ram_rdat = '0;
        if (rd_en) begin
            if (in_ram) begin
                bus.ram_rdat = mem_q[bus.ram_addr];
            end else begin
                case (io_off)
                    8'd0:    bus.ram_rdat = 8'(cnt_q);
                    8'd1:    bus.ram_rdat = status;
                    8'd2:    bus.ram_rdat = treload_q;
                    8'd3:    bus.ram_rdat = tcount_q;
                    default: bus.ram_rdat = '0;
                endcase
            end
        end
    end

    // Next-state for FIFO pointers/count, sticky flags and timer
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        exp_d     = exp_q;
        tcount_d  = tcount_q;
        treload_d = treload_q;

        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop)     rptr_d = rptr_q + 1'b1;
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        // Clear-on-read first so a same-cycle set event takes priority
        if (status_rd) begin
            ovf_d = 1'b0;
            exp_d = 1'b0;
        end
        if (push && full && !pop) ovf_d = 1'b1;

        if (wr_en && sel_trl) begin
            treload_d = bus.ram_wdat;
            tcount_d  = bus.ram_wdat;
        end else if (tcount_q != '0) begin
            tcount_d = tcount_q - 1'b1;
            if (tcount_q == 8'd1) exp_d = 1'b1;
        end
    end

    // Control registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            exp_q     <= 1'b0;
            tcount_q  <= '0;
            treload_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            exp_q     <= exp_d;
            tcount_q  <= tcount_d;
            treload_q <= treload_d;
        end
    end

    // FIFO storage write; writes seen while reset is held are discarded
    always_ff @(posedge clk) begin
        if (rst_ && push_ok) fifo_q[wptr_q] <= bus.ram_wdat;
    end

    // RAM write; contents survive reset but a write pending during reset is dropped
    always_ff @(posedge clk) begin
        if (rst_ && wr_en && in_ram) mem_q[bus.ram_addr] <= bus.ram_wdat;
    end
endmodule

// File: tb/tb_tiny_dmem.sv
// Directed self-checking bench for tiny_dmem (FIFO_DEPTH=4, IO_BASE=F0).
module tb_tiny_dmem;
    localparam logic [7:0] IOB  = 8'hF0;
    localparam logic [7:0] A_OUT = IOB;
    localparam logic [7:0] A_ST  = IOB + 8'd1;
    localparam logic [7:0] A_TRL = IOB + 8'd2;
    localparam logic [7:0] A_TC  = IOB + 8'd3;

    logic clk;
    logic rst_;
    int   n_tests;
    int   n_fail;
    logic [7:0] rd;

    tiny_dmem_if bus ();

    tiny_dmem #(.FIFO_DEPTH(4), .IO_BASE(8'hF0)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.ram_addr = a;
        bus.ram_wdat = d;
        bus.ram_wr_  = 1'b0;
        @(posedge clk);
        #1 bus.ram_wr_ = 1'b1;
    endtask

    // Samples mid-cycle, then lets one edge pass (side effects of the read happen there)
    task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.ram_addr = a;
        bus.ram_rd_  = 1'b0;
        #1 d = bus.ram_rdat;
        @(posedge clk);
        #1 bus.ram_rd_ = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_          = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdat  = '0;
        bus.ram_rd_   = 1'b1;
        bus.ram_wr_   = 1'b1;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        check_eq("rst_valid", 8'(bus.out_valid), 8'h00);
        check_eq("rst_data", bus.out_data, 8'h00);
        bus.ram_addr = A_ST; bus.ram_rd_ = 1'b0;
        #1 check_eq("rst_status", bus.ram_rdat, 8'h02);
        bus.ram_addr = A_TC;
        #1 check_eq("rst_tcount", bus.ram_rdat, 8'h00);
        bus.ram_rd_ = 1'b1;
        @(negedge clk); rst_ = 1'b1;

        // RAM basics and boundaries
        cpu_write(8'h10, 8'h5A);
        cpu_read(8'h10, rd);  check_eq("ram_10", rd, 8'h5A);
        bus.ram_addr = 8'h10; #1 check_eq("ram_rd_hi", bus.ram_rdat, 8'h00);
        cpu_write(8'hEF, 8'hC3);
        cpu_read(8'hEF, rd);  check_eq("ram_EF", rd, 8'hC3);
        cpu_write(8'h00, 8'h11);
        cpu_read(8'h00, rd);  check_eq("ram_00", rd, 8'h11);
        cpu_write(IOB + 8'd5, 8'h99);
        cpu_read(IOB + 8'd5, rd); check_eq("io_unmapped", rd, 8'h00);

        // Read and write in the same cycle returns old data
        cpu_write(8'h20, 8'h33);
        @(negedge clk);
        bus.ram_addr = 8'h20; bus.ram_wdat = 8'h44;
        bus.ram_rd_ = 1'b0; bus.ram_wr_ = 1'b0;
        #1 check_eq("rw_old", bus.ram_rdat, 8'h33);
        @(posedge clk); #1 begin bus.ram_rd_ = 1'b1; bus.ram_wr_ = 1'b1; end
        cpu_read(8'h20, rd); check_eq("rw_new", rd, 8'h44);

        // Overflow: five pushes into a depth-4 FIFO
        for (int i = 1; i <= 5; i++) cpu_write(A_OUT, 8'(i));
        cpu_read(A_ST, rd);  check_eq("ovf_status", rd, 8'h09);
        cpu_read(A_OUT, rd); check_eq("ovf_count", rd, 8'h04);
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check_eq("drain_valid", 8'(bus.out_valid), 8'h01);
            check_eq("drain_data", bus.out_data, 8'(i));
            @(negedge clk);
        end
        check_eq("drain_empty", 8'(bus.out_valid), 8'h00);
        bus.out_ready = 1'b0;
        cpu_read(A_ST, rd); check_eq("drain_status", rd, 8'h02);

        // Push while full with simultaneous pop
        for (int i = 0; i < 4; i++) cpu_write(A_OUT, 8'h10 + 8'(i));
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.ram_addr = A_OUT; bus.ram_wdat = 8'hAA; bus.ram_wr_ = 1'b0;
        @(posedge clk); #1 begin bus.ram_wr_ = 1'b1; bus.out_ready = 1'b0; end
        cpu_read(A_OUT, rd); check_eq("pp_count", rd, 8'h04);
        cpu_read(A_ST, rd);  check_eq("pp_status", rd, 8'h01);
        @(negedge clk);
        bus.out_ready = 1'b1;
        check_eq("pp_d0", bus.out_data, 8'h11); @(negedge clk);
        check_eq("pp_d1", bus.out_data, 8'h12); @(negedge clk);
        check_eq("pp_d2", bus.out_data, 8'h13); @(negedge clk);
        check_eq("pp_d3", bus.out_data, 8'hAA); @(negedge clk);
        check_eq("pp_empty", 8'(bus.out_valid), 8'h00);
        bus.out_ready = 1'b0;

        // Timer countdown and EXP
        cpu_write(A_TRL, 8'h03);
        for (int i = 3; i >= 0; i--) begin
            cpu_read(A_TC, rd); check_eq("tmr_count", rd, 8'(i));
        end
        cpu_read(A_ST, rd);  check_eq("tmr_exp", rd, 8'h06);
        cpu_read(A_ST, rd);  check_eq("tmr_clr", rd, 8'h02);
        cpu_read(A_TRL, rd); check_eq("tmr_reload_rd", rd, 8'h03);

        // Reload in the cycle TCOUNT=1 suppresses EXP
        cpu_write(A_TRL, 8'h03);
        cpu_read(A_TC, rd); check_eq("rl_3", rd, 8'h03);
        cpu_read(A_TC, rd); check_eq("rl_2", rd, 8'h02);
        cpu_write(A_TRL, 8'h07);
        cpu_read(A_ST, rd); check_eq("rl_status", rd, 8'h02);
        cpu_read(A_TC, rd); check_eq("rl_count", rd, 8'h06);
        cpu_write(A_TRL, 8'h00);
        cpu_read(A_TC, rd); check_eq("rl_stop", rd, 8'h00);
        cpu_read(A_ST, rd); check_eq("rl_stop_st", rd, 8'h02);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 3; i++) cpu_write(A_OUT, 8'h21 + 8'(i));
        cpu_write(A_TRL, 8'h09);
        @(negedge clk);
        check_eq("pre_rst_valid", 8'(bus.out_valid), 8'h01);
        #2 rst_ = 1'b0;
        #1 check_eq("arst_valid", 8'(bus.out_valid), 8'h00);
        check_eq("arst_data", bus.out_data, 8'h00);
        bus.ram_rd_ = 1'b0;
        bus.ram_addr = 8'h10; #1 check_eq("arst_ram", bus.ram_rdat, 8'h5A);
        bus.ram_addr = A_ST;  #1 check_eq("arst_status", bus.ram_rdat, 8'h02);
        bus.ram_addr = A_TRL; #1 check_eq("arst_treload", bus.ram_rdat, 8'h00);
        bus.ram_rd_ = 1'b1;
        bus.ram_addr = 8'h10; bus.ram_wdat = 8'hFF; bus.ram_wr_ = 1'b0;
        @(posedge clk); #1 bus.ram_wr_ = 1'b1;
        @(negedge clk); rst_ = 1'b1;
        cpu_read(8'h10, rd); check_eq("arst_ram_kept", rd, 8'h5A);
        cpu_write(A_OUT, 8'h77);
        @(negedge clk);
        check_eq("post_rst_data", bus.out_data, 8'h77);
        cpu_read(A_OUT, rd); check_eq("post_rst_count", rd, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
